// File: rtl/dm_arbiter_if.sv
// Bundle between the cores, the shared data memory and dm_arbiter.
// slave = arbiter side, master = cores plus memory side.
interface dm_arbiter_if #(
    parameter int NCORES = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    localparam int GW = $clog2(NCORES);

    logic [NCORES-1:0]        req;
    logic [NCORES-1:0]        we;
    logic [NCORES*ADDR_W-1:0] addr;
    logic [NCORES*DATA_W-1:0] wdata;
    logic [NCORES-1:0]        ack;
    logic [DATA_W-1:0]        rdata;
    logic [GW-1:0]            grant_id;
    logic                     busy;
    logic                     dm_en;
    logic                     dm_we;
    logic [ADDR_W-1:0]        dm_addr;
    logic [DATA_W-1:0]        dm_wdata;
    logic [DATA_W-1:0]        dm_rdata;

    modport slave (
        input  req, we, addr, wdata, dm_rdata,
        output ack, rdata, grant_id, busy,
        output dm_en, dm_we, dm_addr, dm_wdata
    );

    modport master (
        output req, we, addr, wdata, dm_rdata,
        input  ack, rdata, grant_id, busy,
        input  dm_en, dm_we, dm_addr, dm_wdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter giving NCORES cores shared access to one data memory.
// Each transaction walks IDLE -> ACCESS -> RESP -> IDLE.
module dm_arbiter #(
    parameter int NCORES = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input logic         clk,
    input logic         rst,
    dm_arbiter_if.slave arb
);
    localparam int GW = $clog2(NCORES);
    localparam int CW = GW + 1;
    localparam logic [CW-1:0] NC = CW'(NCORES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       last_q, last_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic                lwe_q, lwe_d;
    logic [NCORES-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                en_q, en_d;
    logic                dwe_q, dwe_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [CW-1:0]       sum;
    logic [GW-1:0]       win;
    logic                found;
    logic [DATA_W-1:0]   rdata_mux;

    // Search starts one past the last served core and wraps.
    always_comb begin
        sum   = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NCORES; k++) begin
            sum = {1'b0, last_q} + CW'(k);
            if (sum >= NC) begin
                sum = sum - NC;
            end
            if (!found && arb.req[sum[GW-1:0]]) begin
                found = 1'b1;
                win   = sum[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= GW'(NCORES - 1);
            grant_q <= '0;
            lwe_q   <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            dwe_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            lwe_q   <= lwe_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            dwe_q   <= dwe_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (found) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The memory answers one cycle after the strobe, i.e. during RESP,
    // so read data is steered straight through while the ack is up.
    always_comb begin
        rdata_mux = rdata_q;
        if (state_q == RESP && !lwe_q) begin
            rdata_mux = arb.dm_rdata;
        end
    end

    always_comb begin
        last_d  = last_q;
        grant_d = grant_q;
        lwe_d   = lwe_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        busy_d  = (state_d != IDLE);
        en_d    = 1'b0;
        dwe_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = win;
                    lwe_d   = arb.we[win];
                    addr_d  = arb.addr[win*ADDR_W +: ADDR_W];
                    wdata_d = arb.wdata[win*DATA_W +: DATA_W];
                    en_d    = 1'b1;
                    dwe_d   = arb.we[win];
                end
            end
            ACCESS: begin
                ack_d = NCORES'(1) << grant_q;
            end
            RESP: begin
                last_d  = grant_q;
                rdata_d = rdata_mux;
            end
            default: begin
                ack_d = '0;
            end
        endcase
    end

    assign arb.ack      = ack_q;
    assign arb.rdata    = rdata_mux;
    assign arb.grant_id = grant_q;
    assign arb.busy     = busy_q;
    assign arb.dm_en    = en_q;
    assign arb.dm_we    = dwe_q;
    assign arb.dm_addr  = addr_q;
    assign arb.dm_wdata = wdata_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small synchronous-read memory model.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_dm_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    dm_arbiter_if #(.NCORES(4), .ADDR_W(16), .DATA_W(16)) bus ();

    dm_arbiter #(.NCORES(4), .ADDR_W(16), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    logic [15:0] mem_rd = 16'h0;
    assign bus.dm_rdata = mem_rd;

    always @(posedge clk) begin
        if (rst) begin
            mem[5] <= 16'h1234;
            for (int i = 0; i < 4; i++) begin
                mem[32+i] <= 16'hA000 + 16'(i);
            end
        end else if (bus.dm_en) begin
            if (bus.dm_we) mem[bus.dm_addr[7:0]] <= bus.dm_wdata;
            mem_rd <= mem[bus.dm_addr[7:0]];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        for (int i = 0; i < 4; i++) begin
            bus.addr[i*16 +: 16] = 16'h0020 + 16'(i);
        end
        step();
        step();
        chk("rst_ack",   32'(bus.ack),      32'h0);
        chk("rst_busy",  32'(bus.busy),     32'h0);
        chk("rst_grant", 32'(bus.grant_id), 32'h0);
        chk("rst_en",    32'(bus.dm_en),    32'h0);
        chk("rst_rdata", 32'(bus.rdata),    32'h0);
        chk("rst_addr",  32'(bus.dm_addr),  32'h0);
        rst = 1'b0;

        // single read from core 0
        bus.addr[0 +: 16] = 16'h0005;
        bus.req = 4'b0001;
        step();
        chk("rd_en",    32'(bus.dm_en),   32'h1);
        chk("rd_we",    32'(bus.dm_we),   32'h0);
        chk("rd_addr",  32'(bus.dm_addr), 32'h5);
        chk("rd_busy",  32'(bus.busy),    32'h1);
        chk("rd_ack1",  32'(bus.ack),     32'h0);
        step();
        chk("rd_ack",   32'(bus.ack),     32'h1);
        chk("rd_data",  32'(bus.rdata),   32'h1234);
        chk("rd_en2",   32'(bus.dm_en),   32'h0);
        bus.req = 4'b0000;
        step();
        chk("rd_idle",  32'(bus.busy),    32'h0);
        chk("rd_ack3",  32'(bus.ack),     32'h0);
        chk("rd_hold",  32'(bus.rdata),   32'h1234);
        bus.addr[0 +: 16] = 16'h0020;

        // single write from core 2
        bus.addr[32 +: 16]  = 16'h0010;
        bus.wdata[32 +: 16] = 16'hBEEF;
        bus.we  = 4'b0100;
        bus.req = 4'b0100;
        chk("wr_en0",   32'(bus.dm_en),    32'h0);
        step();
        chk("wr_en",    32'(bus.dm_en),    32'h1);
        chk("wr_we",    32'(bus.dm_we),    32'h1);
        chk("wr_addr",  32'(bus.dm_addr),  32'h10);
        chk("wr_wdata", 32'(bus.dm_wdata), 32'hBEEF);
        chk("wr_grant", 32'(bus.grant_id), 32'h2);
        step();
        chk("wr_ack",   32'(bus.ack),      32'h4);
        chk("wr_en2",   32'(bus.dm_en),    32'h0);
        chk("wr_we2",   32'(bus.dm_we),    32'h0);
        chk("wr_rhold", 32'(bus.rdata),    32'h1234);
        bus.req = 4'b0000;
        bus.we  = 4'b0000;
        step();
        chk("wr_idle",  32'(bus.busy),     32'h0);
        chk("wr_mem",   32'(mem[16]),      32'hBEEF);
        bus.addr[32 +: 16] = 16'h0022;

        // fairness from a fresh reset
        rst = 1'b1;
        step();
        chk("rst2_grant", 32'(bus.grant_id), 32'h0);
        rst = 1'b0;
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_grant", 32'(bus.grant_id), 32'(k));
            chk("rr_addr",  32'(bus.dm_addr),  32'h20 + 32'(k));
            step();
            chk("rr_ack",   32'(bus.ack),      32'h1 << k);
            chk("rr_data",  32'(bus.rdata),    32'hA000 + 32'(k));
            bus.req[k] = 1'b0;
            if (k == 3) bus.req = 4'b0010;
            step();
            chk("rr_idle",  32'(bus.busy),     32'h0);
        end
        step();
        chk("late1_grant", 32'(bus.grant_id), 32'h1);
        bus.req = 4'b0011;
        step();
        chk("late1_ack",   32'(bus.ack),      32'h2);
        bus.req = 4'b0001;
        step();
        step();
        chk("late0_grant", 32'(bus.grant_id), 32'h0);
        step();
        chk("late0_ack",   32'(bus.ack),      32'h1);
        bus.req = 4'b0000;
        step();

        // core 3 keeps req after its ack; core 0 must win the wrap
        bus.req = 4'b1000;
        step();
        chk("w3_grant", 32'(bus.grant_id), 32'h3);
        step();
        chk("w3_ack",   32'(bus.ack),      32'h8);
        bus.req = 4'b1001;
        step();
        step();
        chk("wrap0_grant", 32'(bus.grant_id), 32'h0);
        step();
        chk("wrap0_ack",   32'(bus.ack),      32'h1);
        bus.req = 4'b1000;
        step();
        step();
        chk("wrap3_grant", 32'(bus.grant_id), 32'h3);
        step();
        chk("wrap3_ack",   32'(bus.ack),      32'h8);
        bus.req = 4'b0000;
        step();

        // core 1 withdraws during ACCESS
        bus.req = 4'b0010;
        step();
        chk("wd_grant", 32'(bus.grant_id), 32'h1);
        bus.req = 4'b0000;
        step();
        chk("wd_ack",   32'(bus.ack),      32'h2);
        chk("wd_data",  32'(bus.rdata),    32'hA001);
        step();
        chk("wd_idle",  32'(bus.busy),     32'h0);
        step();
        chk("wd_noen",  32'(bus.dm_en),    32'h0);
        chk("wd_noack", 32'(bus.ack),      32'h0);

        // reset during ACCESS of a core 2 write
        bus.addr[32 +: 16]  = 16'h0030;
        bus.wdata[32 +: 16] = 16'h5555;
        bus.we  = 4'b0100;
        bus.req = 4'b0100;
        step();
        chk("ra_we",    32'(bus.dm_we),    32'h1);
        rst = 1'b1;
        step();
        chk("ra_ack",   32'(bus.ack),      32'h0);
        chk("ra_we2",   32'(bus.dm_we),    32'h0);
        chk("ra_en2",   32'(bus.dm_en),    32'h0);
        chk("ra_addr",  32'(bus.dm_addr),  32'h0);
        chk("ra_busy",  32'(bus.busy),     32'h0);
        rst = 1'b0;
        bus.req = 4'b0101;
        step();
        chk("ra_g0",    32'(bus.grant_id), 32'h0);
        chk("ra_g0we",  32'(bus.dm_we),    32'h0);
        step();
        chk("ra_ack0",  32'(bus.ack),      32'h1);
        chk("ra_dat0",  32'(bus.rdata),    32'hA000);
        bus.req = 4'b0100;
        step();
        step();
        chk("ra_g2",    32'(bus.grant_id), 32'h2);
        chk("ra_g2we",  32'(bus.dm_we),    32'h1);
        step();
        chk("ra_ack2",  32'(bus.ack),      32'h4);
        bus.req = 4'b0000;
        bus.we  = 4'b0000;
        step();
        chk("end_idle", 32'(bus.busy),     32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter NCORES, default 4: number of processor cores sharing one data memory (DM); legal range 2..8.
REQ-002 Parameter ADDR_W, default 16: DM address width.
REQ-003 Parameter DATA_W, default 16: DM data width, matching the 16-bit core datapath.
REQ-004 clk  in  1: single clock; all state updates on posedge clk.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 req  in  NCORES: per-core access request; bit i belongs to core i.
REQ-007 we  in  NCORES: per-core write flag (1 = write, 0 = read), qualified by req.
REQ-008 addr  in  NCORES*ADDR_W: per-core address; core i at bits [i*ADDR_W +: ADDR_W].
REQ-009 wdata  in  NCORES*DATA_W: per-core write data; core i at bits [i*DATA_W +: DATA_W].
REQ-010 ack  out  NCORES: one-hot, one-cycle completion pulse to the served core.
REQ-011 rdata  out  DATA_W: read data broadcast to all cores; valid only while the served core's ack bit is high.
REQ-012 grant_id  out  clog2(NCORES): index of the core being served; holds the last served index when idle.
REQ-013 busy  out  1: high whenever the FSM is not in IDLE.
REQ-014 dm_en  out  1: DM access strobe.
REQ-015 dm_we  out  1: DM write strobe.
REQ-016 dm_addr  out  ADDR_W: DM address.
REQ-017 dm_wdata  out  DATA_W: DM write data.
REQ-018 dm_rdata  in  DATA_W: DM read data; synchronous read, valid one cycle after dm_en.

Function
REQ-019 All outputs shall be registered.
REQ-020 The FSM shall have exactly three states: IDLE, ACCESS and RESP.
REQ-021 IDLE:
- no request pending -> stay in IDLE;
- req != 0 -> select winner g, latch addr/wdata/we of g, set grant_id = g, go to ACCESS.
REQ-022 ACCESS, one cycle:
- drive dm_en = 1;
- drive dm_we = latched we;
- drive dm_addr and dm_wdata from the latched values;
- go to RESP.
REQ-023 RESP, one cycle:
- dm_en = 0 and dm_we = 0;
- ack[g] = 1;
- for a read, rdata = dm_rdata; for a write, rdata holds its previous value;
- update the priority pointer to g;
- go to IDLE.
REQ-024 Latency: req sampled in IDLE at edge t -> DM strobe during cycle t+1 -> ack high during cycle t+2.
REQ-025 Each transaction shall occupy 3 cycles, including the return to IDLE.
REQ-026 Arbitration shall be round-robin: search starts at (last_served + 1) mod NCORES and ascends with wrap-around; the first requesting core wins.
REQ-027 Requests arriving while in ACCESS or RESP shall not affect the current transaction; they wait for IDLE.
REQ-028 Deassertion of req[g] after the grant shall not abort the transaction: the access completes and ack[g] is still pulsed.
REQ-029 A core holds req, we, addr and wdata stable until it sees ack, then drops req on the following edge.
REQ-030 A core that keeps req high after its ack shall be treated as a new request at lowest priority.
REQ-031 At most one ack bit shall be high in any cycle.
REQ-032 dm_en and dm_we shall never be high outside ACCESS.

Reset
REQ-033 While rst = 1 at a clock edge, the block shall enter IDLE and clear ack, dm_en, dm_we, busy, rdata, dm_addr, dm_wdata and grant_id to 0.
REQ-034 Reset shall set last_served = NCORES-1, so core 0 has highest priority after reset.
REQ-035 Reset asserted during ACCESS or RESP shall abort the transaction: no ack is issued and DM outputs read 0 from the next cycle.

Verification
REQ-036 Single read: req = 0001, addr0 = 0x0005, DM[5] = 0x1234 -> dm_en high at cycle 1; ack = 0001 and rdata = 0x1234 at cycle 2; busy low at cycle 3.
REQ-037 Single write: core 2 writes 0xBEEF to 0x0010 -> exactly one cycle with dm_en = dm_we = 1, dm_addr = 0x0010, dm_wdata = 0xBEEF; ack = 0100 two cycles after the request.
REQ-038 Fairness: all four req held high from reset, each dropped after its ack -> ack order 0,1,2,3, one ack every 3 cycles; a further request from core 1 after core 3's ack is served before core 0.
REQ-039 Wrap-around: last served = 3, req = 1001 -> core 0 served first, then core 3.
REQ-040 Reset mid-operation: rst pulsed during ACCESS of a write -> no ack; dm_we low next cycle; the next request from core 0 is granted first.
REQ-041 Requester withdrawal: core 1 drops req during ACCESS -> ack[1] still pulses; no second access is issued.
